lcd_frame_arbiter: RTL and testbench
====================================

Name: lcd_frame_arbiter

Overview:
- Owns the 32-character frame buffer that drives the 16x2 character LCD: line 1 is character positions 0-15, line 2 is positions 16-31.
- Shares write access among NUM_REQ requesters (bus masters/slaves posting status text) using round-robin arbitration.
- A granted owner may write individual characters or issue a sequenced clear.
- The flattened buffer output feeds the LCD display wrapper's per-character inputs directly.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- MAX_HOLD, 1024, cycles an owner may hold the grant before yielding to a pending requester; legal range 1..65535.
- BLANK_CHAR, 8'h20, fill character used at reset and during clear (ASCII space).

Ports:
- clock  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req  in  NUM_REQ  request per requester, level; held for as long as ownership is wanted
- clr  in  NUM_REQ  clear-screen pulse; acted on only for the current owner
- wr_en  in  NUM_REQ  character write strobe per requester
- wr_addr  in  5*NUM_REQ  character position per requester; slice i is [5i+4:5i]
- wr_data  in  8*NUM_REQ  ASCII character per requester; slice i is [8i+7:8i]
- gnt  out  NUM_REQ  one-hot grant, registered
- busy  out  1  high while a clear sequence runs
- frame_out  out  256  buffer contents; byte k is [8k+7:8k] = character position k
- frame_upd  out  1  one-cycle pulse: buffer changed on the previous edge

Behaviour:
- Reset (asynchronous, active-high) drives:
  - all 32 buffer bytes to BLANK_CHAR;
  - gnt=0, busy=0, frame_upd=0;
  - state to IDLE, hold counter to 0;
  - last_owner to NUM_REQ-1, so requester 0 has first priority after reset.
- A reset asserted mid-clear or mid-ownership aborts immediately; no partial state survives.
- States:
  - IDLE: gnt=0. If any req is high, pick the first requester searching from last_owner+1, wrapping modulo NUM_REQ. Register owner, last_owner and gnt[owner]=1; go to OWN. gnt is therefore visible one cycle after req.
  - OWN: the hold counter increments every cycle, saturating at MAX_HOLD.
    - If req[owner]=0, go to IDLE and drop gnt on the next edge. Any wr_en in that same cycle is still accepted.
    - Else if hold counter >= MAX_HOLD and any other req is high (preempt), go to IDLE, drop gnt and clear the hold counter. The rotation then grants the next requester.
    - Else if clr[owner]=1, go to CLEAR with the clear index at 0 and busy=1 on the next edge. Any simultaneous wr_en is dropped (clear wins).
    - Else if wr_en[owner]=1, write wr_data slice to buffer[wr_addr slice]. The new byte appears on frame_out in the next cycle; frame_upd pulses in that same next cycle.
  - CLEAR: each cycle writes BLANK_CHAR to buffer[index] and increments the index. After writing index 31 (32 cycles total), busy drops.
    - If req[owner] is still high, return to OWN; otherwise go to IDLE.
    - All wr_en and clr inputs are ignored during CLEAR. gnt stays asserted throughout.
    - The hold counter keeps running, but preemption is evaluated only in OWN.
    - frame_upd stays high for each cycle following a clear write.
- Non-owner wr_en and clr are ignored in every state. No error is flagged.
- wr_addr is 5 bits and covers exactly 0..31, so there is no out-of-range case.
- A write to a byte with its existing value still pulses frame_upd.
- The hold counter clears on every new grant.
- gnt is never multi-hot. There is at least one IDLE cycle between two owners (a handover costs 2 cycles).

Test Plan:
- Reset, then idle 5 cycles -> all frame_out bytes = 8'h20; gnt=0, busy=0, frame_upd=0.
- req=2'b01; owner writes 8'h48 to address 0 and 8'h69 to address 17 -> gnt=01 one cycle after req; byte0=8'h48 and byte17=8'h69, each one cycle after its wr_en; frame_upd pulses twice; non-owner wr_en to address 3 leaves byte3=8'h20.
- req=2'b11 held, MAX_HOLD=4 -> gnt sequence 01 (grant cycle plus 4 held cycles), then 00 for one cycle, then 10; grants alternate while both requests remain high.
- Owner fills addresses 0-31 with 8'h41, then pulses clr together with wr_en -> the write is dropped; busy high exactly 32 cycles; all bytes = 8'h20 afterwards; gnt stays high throughout.
- Assert rst at clear index 10 -> immediately all bytes = 8'h20, gnt=0, busy=0; after release, requester 0 wins the first grant.
- Owner drops req in the same cycle as a wr_en to address 5 -> byte5 is updated; gnt drops on the next edge.

Source files
------------

// File: rtl/lcd_frame_arbiter.sv
// Round-robin owner of the 32-byte 16x2 LCD character buffer.
// The owner writes characters or runs a 32-cycle blanking clear.
module lcd_frame_arbiter #(
    parameter int          NUM_REQ    = 2,
    parameter int          MAX_HOLD   = 1024,
    parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     clr,
    input  logic [NUM_REQ-1:0]     wr_en,
    input  logic [5*NUM_REQ-1:0]   wr_addr,
    input  logic [8*NUM_REQ-1:0]   wr_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   busy,
    output logic [255:0]           frame_out,
    output logic                   frame_upd
);

    localparam int          OW       = $clog2(NUM_REQ);
    localparam logic [15:0] HOLD_MAX = 16'(MAX_HOLD);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OWN   = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    logic [1:0]         r_state;
    logic [OW-1:0]      r_owner;
    logic [OW-1:0]      r_last;
    logic [NUM_REQ-1:0] r_gnt;
    logic [15:0]        r_hold;
    logic [4:0]         r_idx;
    logic               r_busy;
    logic               r_upd;
    logic [7:0]         r_buf [32];

    logic               w_own_req;
    logic               w_own_clr;
    logic               w_own_wr;
    logic [4:0]         w_own_addr;
    logic [7:0]         w_own_data;
    logic               w_found;
    logic [OW-1:0]      w_pick;
    logic               w_preempt;
    logic               w_we;
    logic [4:0]         w_waddr;
    logic [7:0]         w_wdata;

    always_comb begin
        w_own_req  = 1'b0;
        w_own_clr  = 1'b0;
        w_own_wr   = 1'b0;
        w_own_addr = '0;
        w_own_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == OW'(i)) begin
                w_own_req  = req[i];
                w_own_clr  = clr[i];
                w_own_wr   = wr_en[i];
                w_own_addr = wr_addr[5*i +: 5];
                w_own_data = wr_data[8*i +: 8];
            end
        end
    end

    // Descending scan so the nearest requester after r_last wins.
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = (int'(r_last) + k) % NUM_REQ;
            if (req[j]) begin
                w_found = 1'b1;
                w_pick  = OW'(j);
            end
        end
    end

    assign w_preempt = (r_hold >= HOLD_MAX) && |(req & ~r_gnt);

    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_own_addr;
        w_wdata = w_own_data;
        if (r_state == S_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_idx;
            w_wdata = BLANK_CHAR;
        end else if (r_state == S_OWN && w_own_wr &&
                     (!w_own_req || (!w_preempt && !w_own_clr))) begin
            w_we = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_last  <= OW'(NUM_REQ - 1);
            r_gnt   <= '0;
            r_hold  <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_upd   <= 1'b0;
            for (int k = 0; k < 32; k++) r_buf[k] <= BLANK_CHAR;
        end else begin
            r_upd <= w_we;
            if (w_we) r_buf[w_waddr] <= w_wdata;
            if (r_state != S_IDLE && r_hold < HOLD_MAX) r_hold <= r_hold + 16'd1;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_pick;
                        r_last  <= w_pick;
                        r_gnt   <= NUM_REQ'(1) << w_pick;
                        r_hold  <= '0;
                        r_state <= S_OWN;
                    end
                end
                S_OWN: begin
                    if (!w_own_req) begin
                        r_gnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (w_preempt) begin
                        r_gnt   <= '0;
                        r_hold  <= '0;
                        r_state <= S_IDLE;
                    end else if (w_own_clr) begin
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_idx <= r_idx + 5'd1;
                    if (r_idx == 5'd31) begin
                        r_busy <= 1'b0;
                        if (w_own_req) begin
                            r_state <= S_OWN;
                        end else begin
                            r_gnt   <= '0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < 32; k++) frame_out[8*k +: 8] = r_buf[k];
    end

    assign gnt       = r_gnt;
    assign busy      = r_busy;
    assign frame_upd = r_upd;

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// Scoreboarded bench for lcd_frame_arbiter: a reference model predicts
// grant/busy/update/buffer per cycle and a monitor compares the DUT.
module tb_lcd_frame_arbiter;

    localparam int MH = 4;

    logic         clock;
    logic         rst;
    logic [1:0]   req;
    logic [1:0]   clr;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [15:0]  wr_data;
    logic [1:0]   gnt;
    logic         busy;
    logic [255:0] frame_out;
    logic         frame_upd;

    lcd_frame_arbiter #(
        .NUM_REQ    (2),
        .MAX_HOLD   (MH),
        .BLANK_CHAR (8'h20)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .req       (req),
        .clr       (clr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .gnt       (gnt),
        .busy      (busy),
        .frame_out (frame_out),
        .frame_upd (frame_upd)
    );

    typedef struct packed {
        logic [1:0]   gnt;
        logic         busy;
        logic         upd;
        logic [255:0] frame;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    logic prev_rst = 1'b0;

    // reference model state: owner < 0 means nobody holds the buffer
    int       m_owner;
    int       m_last;
    int       m_hold;
    bit       m_clearing;
    int       m_pos;
    bit       m_upd;
    bit [7:0] m_buf [32];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic exp_t cur_exp();
        exp_t e;
        e.gnt  = (m_owner < 0) ? 2'b00 : 2'(1 << m_owner);
        e.busy = m_clearing;
        e.upd  = m_upd;
        for (int k = 0; k < 32; k++) e.frame[8*k +: 8] = m_buf[k];
        return e;
    endfunction

    task automatic model_step(input logic r, input logic [1:0] rq,
                              input logic [1:0] cl, input logic [1:0] we,
                              input logic [9:0] ad, input logic [15:0] dt);
        int  old;
        bit  others;
        int  o;
        if (r) begin
            m_owner = -1;
            m_last = 1;
            m_hold = 0;
            m_clearing = 0;
            m_pos = 0;
            m_upd = 0;
            for (int k = 0; k < 32; k++) m_buf[k] = 8'h20;
            return;
        end
        m_upd = 0;
        if (m_owner < 0) begin
            for (int k = 1; k <= 2; k++) begin
                int c;
                c = (m_last + k) % 2;
                if (rq[c]) begin
                    m_owner = c;
                    m_last = c;
                    m_hold = 0;
                    break;
                end
            end
        end else begin
            o = m_owner;
            old = m_hold;
            if (m_hold < MH) m_hold++;
            others = 0;
            for (int k = 0; k < 2; k++) if (k != o && rq[k]) others = 1;
            if (m_clearing) begin
                m_buf[m_pos] = 8'h20;
                m_upd = 1;
                m_pos++;
                if (m_pos == 32) begin
                    m_clearing = 0;
                    if (!rq[o]) m_owner = -1;
                end
            end else if (!rq[o]) begin
                if (we[o]) begin
                    m_buf[ad[5*o +: 5]] = dt[8*o +: 8];
                    m_upd = 1;
                end
                m_owner = -1;
            end else if (old >= MH && others) begin
                m_owner = -1;
                m_hold = 0;
            end else if (cl[o]) begin
                m_clearing = 1;
                m_pos = 0;
            end else if (we[o]) begin
                m_buf[ad[5*o +: 5]] = dt[8*o +: 8];
                m_upd = 1;
            end
        end
    endtask

    task automatic cmp(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [1:0] rq,
                       input logic [1:0] cl, input logic [1:0] we,
                       input logic [9:0] ad, input logic [15:0] dt);
        exp_t e;
        @(negedge clock);
        #1;
        rst = r;
        req = rq;
        clr = cl;
        wr_en = we;
        wr_addr = ad;
        wr_data = dt;
        model_step(r, rq, cl, we, ad, dt);
        e = cur_exp();
        q.push_back(e);
        if (r && !prev_rst) begin
            #1;
            cmp("async_rst_frame", frame_out, e.frame);
            cmp("async_rst_gnt", 256'(gnt), 256'(e.gnt));
            cmp("async_rst_busy", 256'(busy), 256'(e.busy));
        end
        prev_rst = r;
    endtask

    // monitor: one expected record per clock, compared away from the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("gnt", 256'(gnt), 256'(e.gnt));
                cmp("busy", 256'(busy), 256'(e.busy));
                cmp("frame_upd", 256'(frame_upd), 256'(e.upd));
                cmp("frame_out", frame_out, e.frame);
            end
        end
    end

    initial begin
        logic [1:0] rr;
        rst = 1'b1;
        req = '0;
        clr = '0;
        wr_en = '0;
        wr_addr = '0;
        wr_data = '0;

        cyc(1, 2'b00, 2'b00, 2'b00, '0, '0);
        cyc(1, 2'b00, 2'b00, 2'b00, '0, '0);
        repeat (5) cyc(0, 2'b00, 2'b00, 2'b00, '0, '0);

        // single owner writes; requester 1 write to pos 3 must be ignored
        cyc(0, 2'b01, 2'b00, 2'b00, '0, '0);
        cyc(0, 2'b01, 2'b00, 2'b11, {5'd3, 5'd0}, {8'h5a, 8'h48});
        cyc(0, 2'b01, 2'b00, 2'b01, {5'd0, 5'd17}, {8'h00, 8'h69});
        cyc(0, 2'b01, 2'b00, 2'b10, {5'd3, 5'd0}, {8'h5a, 8'h00});
        // owner drops req while writing pos 5
        cyc(0, 2'b00, 2'b00, 2'b01, {5'd0, 5'd5}, {8'h00, 8'h35});
        repeat (2) cyc(0, 2'b00, 2'b00, 2'b00, '0, '0);

        // both requesting: preemption rotates the grant
        repeat (24) cyc(0, 2'b11, 2'b00, 2'b00, '0, '0);
        repeat (2) cyc(0, 2'b00, 2'b00, 2'b00, '0, '0);

        // fill, then clear with a colliding write
        cyc(0, 2'b01, 2'b00, 2'b00, '0, '0);
        for (int i = 0; i < 32; i++)
            cyc(0, 2'b01, 2'b00, 2'b01, {5'd0, 5'(i)}, {8'h00, 8'h41});
        cyc(0, 2'b01, 2'b01, 2'b01, {5'd0, 5'd7}, {8'h00, 8'h55});
        repeat (34) cyc(0, 2'b01, 2'b00, 2'b11, 10'h3ff, 16'h7777);
        cyc(0, 2'b00, 2'b00, 2'b00, '0, '0);
        cyc(0, 2'b00, 2'b00, 2'b00, '0, '0);

        // reset in the middle of a clear
        cyc(0, 2'b01, 2'b00, 2'b00, '0, '0);
        for (int i = 0; i < 32; i++)
            cyc(0, 2'b01, 2'b00, 2'b01, {5'd0, 5'(i)}, {8'h00, 8'h42});
        cyc(0, 2'b01, 2'b01, 2'b00, '0, '0);
        repeat (10) cyc(0, 2'b01, 2'b00, 2'b00, '0, '0);
        cyc(1, 2'b01, 2'b00, 2'b00, '0, '0);
        cyc(0, 2'b11, 2'b00, 2'b00, '0, '0);
        repeat (3) cyc(0, 2'b11, 2'b00, 2'b01, {5'd9, 5'd8}, {8'h62, 8'h61});
        repeat (3) cyc(0, 2'b00, 2'b00, 2'b00, '0, '0);

        // randomized traffic with sticky requests and rare clears
        rr = 2'b00;
        for (int n = 0; n < 2500; n++) begin
            logic [1:0] cl;
            for (int b = 0; b < 2; b++)
                if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
            cl[0] = ($urandom_range(0, 39) == 0);
            cl[1] = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 199) == 0)
                cyc(1, rr, cl, 2'($urandom), 10'($urandom), 16'($urandom));
            else
                cyc(0, rr, cl, 2'($urandom), 10'($urandom), 16'($urandom));
        end

        @(negedge clock);
        @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
